// File: rtl/wave_pkg.sv
// Shared types, widths and sample conversion for the waveform capture block.
package wave_pkg;

  localparam int unsigned VAL_W    = 8;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned DRAW_W   = 10;

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } state_t;

  // Signed audio sample to offset-binary display height (top byte, sign flipped).
  function automatic logic [VAL_W-1:0] to_val8(input logic [SAMPLE_W-1:0] s);
    return VAL_W'((s ^ 16'h8000) >> 8);
  endfunction

endpackage

// File: rtl/wave_capture_if.sv
// Sample stream, frame timing and display read bus of the scope view.
interface wave_capture_if;
  import wave_pkg::*;

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_in;
  logic                frame_clk;
  logic [DRAW_W-1:0]   DrawX;
  logic [DRAW_W-1:0]   next_val;
  logic                capturing;
  logic                swap_pulse;

  modport master (
    output sample_valid, sample_in, frame_clk, DrawX,
    input  next_val, capturing, swap_pulse
  );

  modport slave (
    input  sample_valid, sample_in, frame_clk, DrawX,
    output next_val, capturing, swap_pulse
  );

endinterface

// File: rtl/wave_line_buffer.sv
// Two-bank line store: synchronous write, registered read, no reset so it maps to block RAM.
module wave_line_buffer
  import wave_pkg::*;
#(
  parameter int unsigned COLS = 640
) (
  input  logic              clk,
  input  logic              we,
  input  logic              wr_bank,
  input  logic [DRAW_W-1:0] wr_col,
  input  logic [VAL_W-1:0]  wr_data,
  input  logic              rd_bank,
  input  logic [DRAW_W-1:0] rd_col,
  output logic [VAL_W-1:0]  rd_data
);

  logic [VAL_W-1:0] mem [2][COLS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_col] <= wr_data;
    end
    rd_data <= mem[rd_bank][rd_col];
  end

endmodule

// File: rtl/wave_capture_ctrl.sv
// Decimate, trigger on rising zero-crossing (or timeout), capture one screen line into the
// back bank and swap banks only on a frame edge so a drawn frame never mixes captures.
module wave_capture_ctrl
  import wave_pkg::*;
#(
  parameter int unsigned COLS         = 640,
  parameter int unsigned DECIM        = 4,
  parameter int unsigned TRIG_TIMEOUT = 1024
) (
  input  logic           Clk,
  input  logic           Reset_n,
  wave_capture_if.slave  bus
);

  localparam int unsigned DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned TMO_W = $clog2(TRIG_TIMEOUT + 1);

  localparam logic [DEC_W-1:0]  DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TRIG_TIMEOUT - 1);
  localparam logic [DRAW_W-1:0] COL_LAST = DRAW_W'(COLS - 1);
  localparam logic [DRAW_W-1:0] COL_END  = DRAW_W'(COLS);

  state_t             state;
  logic               disp_bank;
  logic               frame_q;
  logic               prev_neg;
  logic               in_range_q;
  logic [DEC_W-1:0]   dec_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [DRAW_W-1:0]  wr_col;
  logic [VAL_W-1:0]   rd_data;

  logic               keep_c;
  logic               frame_rise_c;
  logic               trig_c;
  logic               we_c;
  logic               in_range_c;
  logic [DRAW_W-1:0]  wr_addr_c;
  logic [DRAW_W-1:0]  rd_col_c;

  assign keep_c       = bus.sample_valid && (dec_cnt == '0);
  assign frame_rise_c = bus.frame_clk && !frame_q;
  assign trig_c       = keep_c && ((prev_neg && !bus.sample_in[SAMPLE_W-1]) ||
                                   (tmo_cnt == TMO_LAST));
  assign we_c         = ((state == ARM) && trig_c) || ((state == CAPTURE) && keep_c);
  assign wr_addr_c    = (state == ARM) ? '0 : wr_col;
  assign in_range_c   = bus.DrawX < COL_END;
  assign rd_col_c     = in_range_c ? bus.DrawX : '0;

  // Out-of-range columns read as zero; both mux inputs come straight from registers.
  assign bus.next_val = in_range_q ? DRAW_W'(rd_data) : '0;

  wave_line_buffer #(.COLS(COLS)) u_line_buffer (
    .clk     (Clk),
    .we      (we_c),
    .wr_bank (~disp_bank),
    .wr_col  (wr_addr_c),
    .wr_data (to_val8(bus.sample_in)),
    .rd_bank (disp_bank),
    .rd_col  (rd_col_c),
    .rd_data (rd_data)
  );

  // Control FSM, decimator, trigger tracking and frame edge detect.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= ARM;
      disp_bank      <= 1'b0;
      frame_q        <= 1'b0;
      prev_neg       <= 1'b0;
      in_range_q     <= 1'b0;
      dec_cnt        <= '0;
      tmo_cnt        <= '0;
      wr_col         <= '0;
      bus.capturing  <= 1'b1;
      bus.swap_pulse <= 1'b0;
    end else begin
      frame_q        <= bus.frame_clk;
      in_range_q     <= in_range_c;
      bus.swap_pulse <= 1'b0;

      if (bus.sample_valid) begin
        dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
      end

      case (state)
        ARM: begin
          if (keep_c) begin
            prev_neg <= bus.sample_in[SAMPLE_W-1];
            if (trig_c) begin
              state   <= CAPTURE;
              wr_col  <= DRAW_W'(1);
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (keep_c) begin
            if (wr_col == COL_LAST) begin
              state         <= READY;
              wr_col        <= '0;
              bus.capturing <= 1'b0;
            end else begin
              wr_col <= wr_col + 1'b1;
            end
          end
        end
        READY: begin
          if (frame_rise_c) begin
            state          <= ARM;
            disp_bank      <= ~disp_bank;
            bus.swap_pulse <= 1'b1;
            bus.capturing  <= 1'b1;
            tmo_cnt        <= '0;
            prev_neg       <= 1'b0;
          end
        end
        default: begin
          state         <= ARM;
          bus.capturing <= 1'b1;
        end
      endcase
    end
  end

endmodule
